// File: rtl/vector_checker_pkg.sv
// Shared types and default sizing for the vector_checker response checker.
// The run FSM has three states; the WIDTH/DEPTH defaults match the reference build.
package vector_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 6;

endpackage

// File: rtl/vc_exp_mem.sv
// Expected-response table: DEPTH x WIDTH register file.
// One synchronous write port and one asynchronous read port.
module vc_exp_mem
    import vector_checker_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDXW-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDXW-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the table has no reset; its contents survive rst_n so a run can restart without a reload.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range indices cannot occur in RUN; return zero so the read stays defined anyway.
    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/vector_checker.sv
// Response checker: accepts DUT words over valid/ready and compares them in order against
// the expected table, reporting pass/fail counts, the first failing index and done.
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int IDXW  = $clog2(DEPTH),
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exp_we,
    input  logic [IDXW-1:0]  exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             start,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ready,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNTW-1:0]  pass_cnt,
    output logic [CNTW-1:0]  fail_cnt,
    output logic             first_fail_vld,
    output logic [IDXW-1:0]  first_fail_idx
);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   pass_d, fail_d;
    logic              ready_d, busy_d, done_d, mismatch_d;
    logic              ffv_d;
    logic [IDXW-1:0]   ffi_d;
    logic [WIDTH-1:0]  exp_word;
    logic              accept;
    logic              last_beat;

    vc_exp_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_exp_mem (
        .clk   (clk),
        .we    (exp_we && (state_q != RUN)),
        .waddr (exp_addr),
        .wdata (exp_data),
        .raddr (idx_q),
        .rdata (exp_word)
    );

    // y_ready is a registered copy of "in RUN", so acceptance needs no combinational path from state.
    assign accept    = y_valid && y_ready;
    assign last_beat = (idx_q == IDXW'(DEPTH - 1));

    // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pass_d     = pass_cnt;
        fail_d     = fail_cnt;
        done_d     = done;
        mismatch_d = 1'b0;
        ffv_d      = first_fail_vld;
        ffi_d      = first_fail_idx;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    ffv_d   = 1'b0;
                    ffi_d   = '0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (y_data == exp_word) begin
                        pass_d = pass_cnt + CNTW'(1);
                    end else begin
                        fail_d     = fail_cnt + CNTW'(1);
                        mismatch_d = 1'b1;
                        if (!first_fail_vld) begin
                            ffv_d = 1'b1;
                            ffi_d = idx_q;
                        end
                    end
                    // idx parks at zero after the final beat so it never needs a DEPTH-th code.
                    if (last_beat) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == RUN);
        busy_d  = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            y_ready        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            y_ready        <= ready_d;
            busy           <= busy_d;
            done           <= done_d;
            mismatch       <= mismatch_d;
            pass_cnt       <= pass_d;
            fail_cnt       <= fail_d;
            first_fail_vld <= ffv_d;
            first_fail_idx <= ffi_d;
        end
    end

endmodule

// File: tb/tb_vector_checker.sv
// Self-checking bench for vector_checker (WIDTH=4, DEPTH=6) with randomized gaps and words,
// checked against an in-bench model of the expected table and run results.
module tb_vector_checker;

    localparam int WIDTH = 4;
    localparam int DEPTH = 6;
    localparam int IDXW  = 3;
    localparam int CNTW  = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             exp_we = 1'b0;
    logic [IDXW-1:0]  exp_addr = '0;
    logic [WIDTH-1:0] exp_data = '0;
    logic             start = 1'b0;
    logic             y_valid = 1'b0;
    logic [WIDTH-1:0] y_data = '0;
    logic             y_ready, busy, done, mismatch;
    logic [CNTW-1:0]  pass_cnt, fail_cnt;
    logic             first_fail_vld;
    logic [IDXW-1:0]  first_fail_idx;

    int tests_run = 0;
    int tests_failed = 0;

    // Bench view of the table and of the response words for the current run.
    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] resp  [DEPTH];

    // {done, busy, y_ready, pass_cnt, fail_cnt, first_fail_vld, first_fail_idx}
    logic [12:0] status;
    assign status = {done, busy, y_ready, pass_cnt, fail_cnt, first_fail_vld, first_fail_idx};

    vector_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exp_we         (exp_we),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .start          (start),
        .y_valid        (y_valid),
        .y_data         (y_data),
        .y_ready        (y_ready),
        .busy           (busy),
        .done           (done),
        .mismatch       (mismatch),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] st(input int d, input int b, input int r, input int p,
                                       input int f, input int v, input int x);
        return {d[0], b[0], r[0], p[2:0], f[2:0], v[0], x[2:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        for (int i = 0; i < DEPTH; i++) begin
            exp_we   = 1'b1;
            exp_addr = IDXW'(i);
            exp_data = model[i];
            tick();
        end
        exp_we = 1'b0;
    endtask

    task automatic start_run(input string name);
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (status !== st(0, 1, 1, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL %s start: status got %h expected %h", name, status, st(0, 1, 1, 0, 0, 0, 0));
        end
    endtask

    // Feeds resp[0..nbeats-1] with random idle gaps and checks each beat against the model.
    task automatic run_vectors(input string name, input int min_gap, input int max_gap, input int nbeats);
        int p = 0, f = 0, v = 0, x = 0;
        logic bad;
        for (int i = 0; i < nbeats; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
            y_valid = 1'b0;
            for (int k = 0; k < g; k++) begin
                y_data = WIDTH'($urandom);
                tick();
                tests_run++;
                if ({mismatch, status} !== {1'b0, st(0, 1, 1, p, f, v, x)}) begin
                    tests_failed++;
                    $display("FAIL %s gap%0d: got %h expected %h", name, i,
                             {mismatch, status}, {1'b0, st(0, 1, 1, p, f, v, x)});
                end
            end
            tests_run++;
            if (y_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s ready%0d: y_ready got %b expected 1", name, i, y_ready);
            end
            y_valid = 1'b1;
            y_data  = resp[i];
            tick();
            bad = (resp[i] != model[i]);
            if (bad) begin
                f++;
                if (v == 0) begin
                    v = 1;
                    x = i;
                end
            end else begin
                p++;
            end
            tests_run++;
            if ({mismatch, status} !== {bad, st(i == DEPTH - 1, i != DEPTH - 1, i != DEPTH - 1, p, f, v, x)}) begin
                tests_failed++;
                $display("FAIL %s beat%0d: got %h expected %h", name, i, {mismatch, status},
                         {bad, st(i == DEPTH - 1, i != DEPTH - 1, i != DEPTH - 1, p, f, v, x)});
            end
        end
        y_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if ({mismatch, status} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset: got %h expected 0", {mismatch, status});
        end
        rst_n = 1'b1;
        tick();
        y_valid = 1'b1;
        y_data  = 4'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if ({mismatch, status} !== 14'd0) begin
                tests_failed++;
                $display("FAIL idle_valid%0d: got %h expected 0", k, {mismatch, status});
            end
        end
        y_valid = 1'b0;
    endtask

    task automatic test_match();
        model = '{4'd3, 4'd5, 4'd0, 4'd15, 4'd8, 4'd1};
        load_table();
        resp = model;
        start_run("match");
        run_vectors("match", 0, 0, DEPTH);
    endtask

    task automatic test_mismatch();
        resp = '{4'd3, 4'd5, 4'd7, 4'd15, 4'd9, 4'd1};
        start_run("mismatch");
        run_vectors("mismatch", 0, 0, DEPTH);
        tests_run++;
        if ({fail_cnt, pass_cnt, first_fail_idx} !== {3'd2, 3'd4, 3'd2}) begin
            tests_failed++;
            $display("FAIL mismatch_totals: fail/pass/idx got %0d/%0d/%0d expected 2/4/2",
                     fail_cnt, pass_cnt, first_fail_idx);
        end
    endtask

    task automatic test_gaps();
        resp = model;
        start_run("gaps");
        run_vectors("gaps", 1, 3, DEPTH);
    endtask

    task automatic test_reset_midrun();
        resp = model;
        start_run("midrst");
        run_vectors("midrst", 0, 1, 3);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({mismatch, status} !== 14'd0) begin
            tests_failed++;
            $display("FAIL midrst_abort: got %h expected 0", {mismatch, status});
        end
        #3;
        rst_n = 1'b1;
        tick();
        start_run("midrst_re");
        run_vectors("midrst_re", 0, 0, DEPTH);
    endtask

    task automatic test_run_ignores();
        resp = model;
        start_run("ignore");
        start    = 1'b1;
        exp_we   = 1'b1;
        exp_addr = '0;
        exp_data = 4'd9;
        tick();
        start  = 1'b0;
        exp_we = 1'b0;
        tests_run++;
        if (status !== st(0, 1, 1, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL ignore_start: status got %h expected %h", status, st(0, 1, 1, 0, 0, 0, 0));
        end
        run_vectors("ignore", 0, 2, DEPTH);
        y_valid = 1'b1;
        y_data  = 4'd7;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests_run++;
            if ({mismatch, status} !== {1'b0, st(1, 0, 0, DEPTH, 0, 0, 0)}) begin
                tests_failed++;
                $display("FAIL done_valid%0d: got %h expected %h", k, {mismatch, status},
                         {1'b0, st(1, 0, 0, DEPTH, 0, 0, 0)});
            end
        end
        y_valid = 1'b0;
    endtask

    task automatic test_restart_write();
        resp = '{4'd3, 4'd0, 4'd0, 4'd15, 4'd8, 4'd2};
        start_run("pre");
        run_vectors("pre", 0, 0, DEPTH);
        model[0] = 4'd4;
        exp_we   = 1'b1;
        exp_addr = '0;
        exp_data = 4'd4;
        start_run("restart_we");
        exp_we = 1'b0;
        resp = '{4'd4, 4'd5, 4'd0, 4'd15, 4'd8, 4'd1};
        run_vectors("restart_we", 0, 0, DEPTH);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) model[i] = WIDTH'($urandom);
            load_table();
            exp_we = 1'b1;
            for (int a = DEPTH; a < 8; a++) begin
                exp_addr = IDXW'(a);
                exp_data = WIDTH'($urandom);
                tick();
            end
            exp_we = 1'b0;
            for (int i = 0; i < DEPTH; i++)
                resp[i] = ($urandom_range(1, 0) == 1) ? model[i] : WIDTH'($urandom);
            start_run("random");
            run_vectors("random", 0, 2, DEPTH);
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_gaps();
        test_reset_midrun();
        test_run_ignores();
        test_restart_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
